// File: rtl/uart_request_framer_pkg.sv
// Shared types for the UART request framer and the instruction decoder:
// frame state encoding, error codes, command width and the legality helper.
package uart_request_framer_pkg;

  typedef enum logic [2:0] {
    WAIT_CMD,
    WAIT_ADDR,
    WAIT_CSUM,
    CHECK,
    OUT,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CMD     = 2'b01;
  localparam logic [1:0] ERR_ADDR    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int CMD_W = 3;
  typedef logic [CMD_W-1:0] cmd_t;

  // Edges on which rx_rdy is ignored after a consume: the rdy_clr cycle plus
  // two cycles of flag-clear latency inside the UART.
  localparam int RX_BLANK = 3;

  function automatic logic cmd_legal(input logic [7:0] c, input int max_cmd);
    return int'(c) <= max_cmd;
  endfunction

endpackage

// File: rtl/uart_request_framer_if.sv
// Bundle of UART-side, control-side and error-side signals of the framer.
// master = framer side, slave = UART/decoder/packer side.
interface uart_request_framer_if #(
  parameter int ADDR_W = 5
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              idle;
  logic              continuous;
  logic              rdy_clr;
  logic [2:0]        instr;
  logic [ADDR_W-1:0] addr;
  logic              req_valid;
  logic              err_valid;
  logic [1:0]        err_code;

  modport master (
    input  rx_rdy, rx_data, idle, continuous,
    output rdy_clr, instr, addr, req_valid, err_valid, err_code
  );

  modport slave (
    output rx_rdy, rx_data, idle, continuous,
    input  rdy_clr, instr, addr, req_valid, err_valid, err_code
  );
endinterface

// File: rtl/uart_request_framer_frame_timeout_timer.sv
// Saturating inter-byte timer: cleared at each frame byte, counts while enabled,
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_request_framer.sv
// Receive-side request framer: gathers cmd/addr bytes from the UART, validates
// them and emits a request or error pulse. Macro REQ_CHECKSUM_EN adds a csum byte.
module uart_request_framer
  import uart_request_framer_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 20,
  parameter int MAX_CMD        = 6,
  parameter int NUM_SENSORS    = 32,
  parameter int ADDR_W         = 5
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  uart_request_framer_if.master  bus
);

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        addr_q, addr_d;
  cmd_t              instr_q, instr_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              rdy_clr_q, rdy_clr_d;
  logic [1:0]        blank_q, blank_d;
  logic              byte_take;
  logic              tmr_clear, tmr_en, tmr_expired;
`ifdef REQ_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign byte_take = bus.rx_rdy && (blank_q == 2'd0);

  frame_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    addr_out_d = addr_out_q;
    err_code_d = err_code_q;
    rdy_clr_d  = 1'b0;
    blank_d    = (blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
`ifdef REQ_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      WAIT_CMD: begin
        if (byte_take) begin
          rdy_clr_d = 1'b1;
          blank_d   = 2'(RX_BLANK);
          // Bytes arriving while the controller is busy are drained silently.
          if (bus.idle || bus.continuous) begin
            cmd_d     = bus.rx_data;
            tmr_clear = 1'b1;
            state_d   = WAIT_ADDR;
          end
        end
      end

      WAIT_ADDR: begin
        tmr_en = 1'b1;
        if (byte_take) begin
          rdy_clr_d = 1'b1;
          blank_d   = 2'(RX_BLANK);
          addr_d    = bus.rx_data;
`ifdef REQ_CHECKSUM_EN
          tmr_clear = 1'b1;
          state_d   = WAIT_CSUM;
`else
          state_d   = CHECK;
`endif
        end else if (tmr_expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
        end
      end

`ifdef REQ_CHECKSUM_EN
      WAIT_CSUM: begin
        tmr_en = 1'b1;
        if (byte_take) begin
          rdy_clr_d = 1'b1;
          blank_d   = 2'(RX_BLANK);
          csum_d    = bus.rx_data;
          state_d   = CHECK;
        end else if (tmr_expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
        end
      end
`endif

      CHECK: begin
        if (!cmd_legal(cmd_q, MAX_CMD)) begin
          err_code_d = ERR_CMD;
          state_d    = ERR;
`ifdef REQ_CHECKSUM_EN
        end else if (csum_q != (cmd_q ^ addr_q)) begin
          err_code_d = ERR_CMD;
          state_d    = ERR;
`endif
        end else if (int'(addr_q) >= NUM_SENSORS) begin
          err_code_d = ERR_ADDR;
          state_d    = ERR;
        end else begin
          instr_d    = cmd_q[CMD_W-1:0];
          addr_out_d = addr_q[ADDR_W-1:0];
          err_code_d = ERR_NONE;
          state_d    = OUT;
        end
      end

      OUT:     state_d = WAIT_CMD;
      ERR:     state_d = WAIT_CMD;
      default: state_d = WAIT_CMD;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_CMD;
      cmd_q      <= '0;
      addr_q     <= '0;
      instr_q    <= '0;
      addr_out_q <= '0;
      err_code_q <= ERR_NONE;
      rdy_clr_q  <= 1'b0;
      blank_q    <= '0;
`ifdef REQ_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      addr_out_q <= addr_out_d;
      err_code_q <= err_code_d;
      rdy_clr_q  <= rdy_clr_d;
      blank_q    <= blank_d;
`ifdef REQ_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.rdy_clr   = rdy_clr_q;
  assign bus.instr     = instr_q;
  assign bus.addr      = addr_out_q;
  assign bus.req_valid = (state_q == OUT);
  assign bus.err_valid = (state_q == ERR);
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_request_framer.sv
// Directed bench for uart_request_framer: table of frames plus hand-written
// sequences for latency, exact timeout and mid-frame reset.
module tb_uart_request_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_request_framer_if #(.ADDR_W(5)) bus ();

  uart_request_framer #(
    .CLK_HZ         (50_000_000),
    .TIMEOUT_CYCLES (100),
    .MAX_CMD        (6),
    .NUM_SENSORS    (32),
    .ADDR_W         (5)
  ) dut (
    .clk_50m (clk),
    .rst_n   (rst_n),
    .bus     (bus.master)
  );

  int total = 0;
  int bad   = 0;

  int req_cnt = 0, err_cnt = 0, clr_cnt = 0;
  logic [2:0] last_instr = '0;
  logic [4:0] last_addr  = '0;
  logic [1:0] last_code  = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_valid) begin
        req_cnt++;
        last_instr = bus.instr;
        last_addr  = bus.addr;
      end
      if (bus.err_valid) begin
        err_cnt++;
        last_code = bus.err_code;
      end
      if (bus.rdy_clr) clr_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // UART model: hold rx_rdy until rdy_clr, drop the flag one edge later.
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rdy_clr && n < 50);
    if (!bus.rdy_clr) begin
      total++;
      bad++;
      $display("FAIL rdy_clr_wait: byte %02h never consumed within 50 cycles", b);
    end
    @(posedge clk);
    #1;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         nb;
    logic       idle, cont;
    int         wait_c;
    int         exp_req, exp_err;
    logic [1:0] exp_code;
    logic [2:0] exp_instr;
    logic [4:0] exp_addr;
  } vec_t;

  vec_t vecs[12];
  int   nv;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int r0, e0, c0, nsent, n, got_n;
    logic lat_before, lat_after;

    bus.rx_rdy = 1'b0; bus.rx_data = 8'h00;
    bus.idle = 1'b1;   bus.continuous = 1'b0;

    //            b0     b1     b2    nb idle cont wait req err code  instr addr
    vecs[0]  = '{8'h02, 8'h05, 8'h00, 2, 1'b1, 1'b0,  10, 1, 0, 2'b00, 3'd2, 5'd5};
    vecs[1]  = '{8'h07, 8'h01, 8'h00, 2, 1'b1, 1'b0,  10, 0, 1, 2'b01, 3'd0, 5'd0};
    vecs[2]  = '{8'h03, 8'h20, 8'h00, 2, 1'b1, 1'b0,  10, 0, 1, 2'b10, 3'd0, 5'd0};
    vecs[3]  = '{8'h01, 8'h00, 8'h00, 1, 1'b1, 1'b0, 130, 0, 1, 2'b11, 3'd0, 5'd0};
    vecs[4]  = '{8'h01, 8'h00, 8'h00, 2, 1'b1, 1'b0,  10, 1, 0, 2'b00, 3'd1, 5'd0};
    vecs[5]  = '{8'h04, 8'h00, 8'h00, 1, 1'b0, 1'b0, 130, 0, 0, 2'b00, 3'd0, 5'd0};
    vecs[6]  = '{8'h04, 8'h1F, 8'h00, 2, 1'b0, 1'b1,  10, 1, 0, 2'b00, 3'd4, 5'd31};
    vecs[7]  = '{8'h06, 8'h00, 8'h00, 2, 1'b1, 1'b0,  10, 1, 0, 2'b00, 3'd6, 5'd0};
    vecs[8]  = '{8'hFF, 8'hFF, 8'h00, 2, 1'b1, 1'b0,  10, 0, 1, 2'b01, 3'd0, 5'd0};
    vecs[9]  = '{8'h05, 8'h11, 8'h00, 2, 1'b1, 1'b0,  10, 1, 0, 2'b00, 3'd5, 5'd17};
    nv = 10;
`ifdef REQ_CHECKSUM_EN
    vecs[10] = '{8'h02, 8'h05, 8'h07, 3, 1'b1, 1'b0,  10, 1, 0, 2'b00, 3'd2, 5'd5};
    vecs[11] = '{8'h02, 8'h05, 8'h06, 3, 1'b1, 1'b0,  10, 0, 1, 2'b01, 3'd0, 5'd0};
    nv = 12;
`endif

    repeat (3) @(negedge clk);
    check("rst_req_valid", int'(bus.req_valid), 0);
    check("rst_err_valid", int'(bus.err_valid), 0);
    check("rst_rdy_clr",   int'(bus.rdy_clr),   0);
    check("rst_err_code",  int'(bus.err_code),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < nv; i++) begin
      v = vecs[i];
      bus.idle = v.idle;
      bus.continuous = v.cont;
      r0 = req_cnt; e0 = err_cnt; c0 = clr_cnt;
      nsent = v.nb;
      send_byte(v.b0);
      if (v.nb > 1) send_byte(v.b1);
      if (v.nb > 2) send_byte(v.b2);
`ifdef REQ_CHECKSUM_EN
      if (v.nb == 2) begin
        send_byte(v.b0 ^ v.b1);
        nsent++;
      end
`endif
      repeat (v.wait_c) @(negedge clk);
      $display("vec %0d: bytes %02h %02h nb=%0d idle=%0b cont=%0b -> req=%0d err=%0d clr=%0d",
               i, v.b0, v.b1, nsent, v.idle, v.cont, req_cnt - r0, err_cnt - e0, clr_cnt - c0);
      check($sformatf("v%0d_req_cnt", i), req_cnt - r0, v.exp_req);
      check($sformatf("v%0d_err_cnt", i), err_cnt - e0, v.exp_err);
      check($sformatf("v%0d_clr_cnt", i), clr_cnt - c0, nsent);
      if (v.exp_req != 0) begin
        check($sformatf("v%0d_instr", i), int'(last_instr), int'(v.exp_instr));
        check($sformatf("v%0d_addr", i),  int'(last_addr),  int'(v.exp_addr));
      end
      if (v.exp_err != 0)
        check($sformatf("v%0d_err_code", i), int'(last_code), int'(v.exp_code));
    end

    // Latency: req_valid exactly one cycle after the final byte's rdy_clr.
    bus.idle = 1'b1; bus.continuous = 1'b0;
    send_byte(8'h03);
`ifdef REQ_CHECKSUM_EN
    send_byte(8'h04);
    bus.rx_data = 8'h07;
`else
    bus.rx_data = 8'h04;
`endif
    bus.rx_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rdy_clr && n < 50);
    lat_before = bus.req_valid;
    @(negedge clk);
    lat_after = bus.req_valid;
    bus.rx_rdy = 1'b0;
    $display("latency seq: req_valid at rdy_clr=%0b, one cycle later=%0b", lat_before, lat_after);
    check("lat_rdy_clr_seen", int'(bus.rdy_clr === 1'b0 || n < 50), 1);
    check("lat_req_early", int'(lat_before), 0);
    check("lat_req_valid", int'(lat_after), 1);
    check("lat_instr", int'(bus.instr), 3);
    repeat (6) @(negedge clk);

    // Exact timeout: WAIT_ADDR lasts 100 cycles, err_valid follows.
    bus.rx_data = 8'h01;
    bus.rx_rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rdy_clr && n < 50);
    got_n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) bus.rx_rdy = 1'b0;
      if (bus.err_valid && got_n < 0) begin
        got_n = k;
        break;
      end
    end
    $display("timeout seq: err_valid %0d cycles after rdy_clr, code=%0d", got_n, bus.err_code);
    check("timeout_cycle", got_n, 100);
    check("timeout_code", int'(bus.err_code), 3);
    repeat (4) @(negedge clk);

    // Mid-frame reset drops outputs at once and discards the partial frame.
    send_byte(8'h02);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset seq: instr=%0d addr=%0d req=%0b err=%0b", bus.instr, bus.addr, bus.req_valid, bus.err_valid);
    check("mrst_instr",     int'(bus.instr),     0);
    check("mrst_addr",      int'(bus.addr),      0);
    check("mrst_req_valid", int'(bus.req_valid), 0);
    check("mrst_err_valid", int'(bus.err_valid), 0);
    check("mrst_rdy_clr",   int'(bus.rdy_clr),   0);
    check("mrst_err_code",  int'(bus.err_code),  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    r0 = req_cnt; e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef REQ_CHECKSUM_EN
    send_byte(8'h00);
`endif
    repeat (10) @(negedge clk);
    $display("post-reset frame: req=%0d err=%0d instr=%0d addr=%0d", req_cnt - r0, err_cnt - e0, last_instr, last_addr);
    check("prst_req_cnt", req_cnt - r0, 1);
    check("prst_err_cnt", err_cnt - e0, 0);
    check("prst_instr", int'(last_instr), 0);
    check("prst_addr",  int'(last_addr),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_request_framer.md
Name: uart_request_framer

Overview:
Receive-side framing stage between the UART receiver and the instruction decoder / main state machine.
- Collects the byte-serial request from the PC (command byte, then address byte), checks it and enforces an inter-byte timeout.
- Presents a single-cycle validated request {instr, addr} to the control path, or an error code to the packer path.
- Clears the UART ready flag for every byte it consumes.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; used only to derive the timeout default
TIMEOUT_CYCLES, 2_500_000, maximum cycles allowed between bytes of one frame (50 ms at 50 MHz)
MAX_CMD, 6, highest legal command code; codes MAX_CMD+1..255 are rejected
NUM_SENSORS, 32, number of addressable sensors; legal address is 0..NUM_SENSORS-1
ADDR_W, 5, width of addr output; must satisfy 2^ADDR_W >= NUM_SENSORS

Ports:
clk_50m  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  UART byte-available flag; level, held until rdy_clr
rx_data  in  8  UART received byte; valid while rx_rdy=1
idle  in  1  main state machine is idle and can accept a request
continuous  in  1  continuous-reporting mode active; requests still accepted
rdy_clr  out  1  one-cycle pulse clearing the UART rx_rdy flag
instr  out  3  command code of the last accepted request
addr  out  ADDR_W  sensor address of the last accepted request
req_valid  out  1  one-cycle pulse: instr/addr hold a new valid request
err_valid  out  1  one-cycle pulse: frame rejected; err_code valid
err_code  out  2  01 bad command, 10 bad address, 11 timeout, 00 none

Behaviour:
- Reset (async, rst_n=0): state=WAIT_CMD; instr=0, addr=0, req_valid=0, err_valid=0, err_code=00, rdy_clr=0; timeout counter=0. Reset mid-frame discards the partial frame.
- Byte consumption: on the cycle rx_rdy=1 is sampled in a byte-accepting state, the byte is registered and rdy_clr pulses on the next cycle. rx_rdy is ignored for 2 cycles after rdy_clr, covering the flag clear latency.
- Admission: in WAIT_CMD, a byte is accepted only if idle=1 or continuous=1. Otherwise the byte is drained (rdy_clr pulsed) and discarded, with no error.
- States:
  - WAIT_CMD: accept byte -> cmd_reg; timer cleared -> WAIT_ADDR.
  - WAIT_ADDR: timer counts each cycle.
    - Byte arrives -> addr_reg, then CHECK.
    - Timer reaches TIMEOUT_CYCLES-1 with no byte -> ERR with code 11.
    - If byte and timeout coincide, the byte wins.
  - CHECK (1 cycle):
    - cmd_reg > MAX_CMD -> ERR, code 01. This takes priority over a bad address.
    - Else addr_reg >= NUM_SENSORS -> ERR, code 10.
    - Else -> OUT.
  - OUT (1 cycle): instr=cmd_reg[2:0], addr=addr_reg[ADDR_W-1:0]; req_valid=1 -> WAIT_CMD.
  - ERR (1 cycle): err_code set, err_valid=1 -> WAIT_CMD. err_code holds until the next frame result.
- Latency: req_valid asserts 2 cycles after the cycle the address byte is sampled.
- instr/addr hold their value between requests; the downstream decoder reads them combinationally.
- Timer is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and saturates; it never wraps.
- A byte arriving during CHECK/OUT/ERR stays pending (rx_rdy held) and is consumed in WAIT_CMD.

Optional Feature:
Macro REQ_CHECKSUM_EN.
- Defined: frames are 3 bytes. WAIT_CSUM follows WAIT_ADDR with the same timeout rule. CHECK additionally requires csum == cmd XOR addr; on mismatch, ERR with code 01 (reported as a bad command). Latency is then measured from the checksum byte.
- Undefined: 2-byte frames; no WAIT_CSUM state or checksum register is synthesized.

Decomposition:
- Shared package: state enum (WAIT_CMD, WAIT_ADDR, WAIT_CSUM, CHECK, OUT, ERR); err_code constants ERR_NONE/ERR_CMD/ERR_ADDR/ERR_TIMEOUT.
- Command codes are shared with instr_decoder through the same package.
- One natural sub-module: frame_timeout_timer (clear, enable, expired) with saturating counter.

Test Plan:
- idle=1; bytes 0x02 then 0x05 -> req_valid pulse, instr=3'b010, addr=5, err_valid=0; exactly two rdy_clr pulses.
- Command 0x07 then 0x01 -> err_valid, err_code=01, no req_valid. Repeat with 0x03 then 0x20 -> err_code=10.
- 0x01, then no byte for TIMEOUT_CYCLES (override to 100) -> err_code=11 at cycle 100. A following 0x01, 0x00 is accepted normally.
- idle=0, continuous=0; byte 0x04 -> rdy_clr pulses, no req_valid/err_valid. Same byte with continuous=1 -> frame proceeds.
- rst_n low while in WAIT_ADDR -> all outputs zero immediately. A new 0x00, 0x00 frame after release -> req_valid.
- With REQ_CHECKSUM_EN: 0x02, 0x05, 0x07 -> req_valid. Checksum byte 0x06 -> err_code=01.
